// File: rtl/qspi_arb_pkg.sv
// Shared constants and the address decoder for the QSPI bus arbiter.
package qspi_arb_pkg;

  localparam int ADDR_SEL_BIT  = 24;  // 0: flash, 1: RAM
  localparam int RAM_BANK_BIT  = 23;  // 0: RAM A, 1: RAM B

  localparam logic [1:0] SEL_FLASH = 2'd0;
  localparam logic [1:0] SEL_RAM_A = 2'd1;
  localparam logic [1:0] SEL_RAM_B = 2'd2;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ISSUE = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_RESP  = 3'd3;
  localparam state_t ST_ERR   = 3'd4;

  typedef struct packed {
    logic [1:0]  sel;
    logic [23:0] addr;
  } dev_target_t;

  // Flash sees a 16 MiB window; each RAM bank sees 8 MiB, zero-extended.
  function automatic dev_target_t decode_addr(input logic [24:0] addr);
    dev_target_t t;
    if (!addr[ADDR_SEL_BIT]) begin
      t.sel  = SEL_FLASH;
      t.addr = addr[23:0];
    end else begin
      t.sel  = addr[RAM_BANK_BIT] ? SEL_RAM_B : SEL_RAM_A;
      t.addr = {1'b0, addr[22:0]};
    end
    return t;
  endfunction

endpackage

// File: rtl/qspi_bus_arbiter.sv
// Arbitrates fetch and data requesters onto one QSPI transfer engine.
// Optional fetch anti-starvation guard: define QSPI_ARB_STARVE_GUARD_EN.
module qspi_bus_arbiter
  import qspi_arb_pkg::*;
#(
  parameter int ADDR_W       = 25,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic              i_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic              d_rvalid,
  output logic              d_err,
  output logic [31:0]       rdata,
  output logic              ctrl_start,
  output logic [1:0]        ctrl_sel,
  output logic [23:0]       ctrl_addr,
  output logic              ctrl_we,
  output logic [31:0]       ctrl_wdata,
  input  logic              ctrl_done,
  input  logic [31:0]       ctrl_rdata
);

  state_t      state;
  logic        owner_data;
  logic        starved;
  logic        fetch_win;
  logic        data_win;
  logic        flash_wr;
  dev_target_t i_tgt;
  dev_target_t d_tgt;

  assign i_tgt     = decode_addr(i_addr);
  assign d_tgt     = decode_addr(d_addr);
  assign fetch_win = i_req && (!d_req || starved);
  assign data_win  = d_req && !fetch_win;
  assign flash_wr  = d_we && (d_tgt.sel == SEL_FLASH);

`ifdef QSPI_ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt;

  assign starved = (starve_cnt >= 3'(STARVE_LIMIT));

  // Counts data grants that overtook a waiting fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (fetch_win)
        starve_cnt <= '0;
      else if (data_win)
        starve_cnt <= i_req ? starve_cnt + 3'd1 : 3'd0;
    end
  end
`else
  assign starved = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner_data <= 1'b0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rvalid   <= 1'b0;
      d_rvalid   <= 1'b0;
      d_err      <= 1'b0;
      rdata      <= '0;
      ctrl_start <= 1'b0;
      ctrl_sel   <= SEL_FLASH;
      ctrl_addr  <= '0;
      ctrl_we    <= 1'b0;
      ctrl_wdata <= '0;
    end else begin
      // Every handshake output is a single-cycle pulse by default.
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rvalid   <= 1'b0;
      d_rvalid   <= 1'b0;
      d_err      <= 1'b0;
      ctrl_start <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (fetch_win) begin
            i_ack      <= 1'b1;
            owner_data <= 1'b0;
            ctrl_sel   <= i_tgt.sel;
            ctrl_addr  <= i_tgt.addr;
            ctrl_we    <= 1'b0;
            ctrl_wdata <= '0;
            state      <= ST_ISSUE;
          end else if (data_win) begin
            d_ack      <= 1'b1;
            owner_data <= 1'b1;
            if (flash_wr) begin
              state <= ST_ERR;
            end else begin
              ctrl_sel   <= d_tgt.sel;
              ctrl_addr  <= d_tgt.addr;
              ctrl_we    <= d_we;
              ctrl_wdata <= d_wdata;
              state      <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          ctrl_start <= 1'b1;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ctrl_done) begin
            rdata    <= ctrl_rdata;
            i_rvalid <= !owner_data;
            d_rvalid <= owner_data;
            state    <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        ST_ERR: begin
          d_err <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Scoreboard bench for qspi_bus_arbiter with a behavioural memory-backed engine.
module tb_qspi_bus_arbiter;

  localparam int LIMIT = 4;
`ifdef QSPI_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [24:0] i_addr, d_addr;
  logic [31:0] d_wdata;
  logic        i_ack, i_rvalid, d_ack, d_rvalid, d_err;
  logic [31:0] rdata;
  logic        ctrl_start, ctrl_we, ctrl_done;
  logic [1:0]  ctrl_sel;
  logic [23:0] ctrl_addr;
  logic [31:0] ctrl_wdata, ctrl_rdata;

  qspi_bus_arbiter #(.ADDR_W(25), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rvalid(i_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rvalid(d_rvalid), .d_err(d_err), .rdata(rdata),
    .ctrl_start(ctrl_start), .ctrl_sel(ctrl_sel), .ctrl_addr(ctrl_addr),
    .ctrl_we(ctrl_we), .ctrl_wdata(ctrl_wdata),
    .ctrl_done(ctrl_done), .ctrl_rdata(ctrl_rdata)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_IACK, EV_DACK, EV_CMD, EV_IRESP, EV_DRESP, EV_DERR} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [1:0]  sel;
    logic [23:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } ev_t;

  ev_t         exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] m_mem[logic [25:0]];
  logic [31:0] e_mem[logic [25:0]];
  int          m_cnt = 0;
  logic [31:0] last_rd = '0;
  int          fixed_dly = 0;
  bit          spur_pulse = 1'b0;
  logic        dl_we[8];
  logic [24:0] dl_addr[8];
  logic [31:0] dl_wd[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] init_word(input logic [25:0] key);
    return 32'(key) * 32'h9E37_79B1 ^ 32'h5A5A_A5A5;
  endfunction

  // Reference decode from the address map: flash below 16M, then RAM A, then RAM B.
  function automatic logic [1:0] m_sel(input logic [24:0] a);
    if (a < 25'h100_0000) return 2'd0;
    if (a < 25'h180_0000) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [23:0] m_loc(input logic [24:0] a);
    if (m_sel(a) == 2'd0) return 24'(a % 25'h100_0000);
    return 24'(a % 25'h80_0000);
  endfunction

  function automatic logic [31:0] m_read(input logic [25:0] key);
    return m_mem.exists(key) ? m_mem[key] : init_word(key);
  endfunction

  function automatic ev_t mk(input ev_kind_e k);
    ev_t e;
    e.kind = k; e.sel = '0; e.addr = '0; e.we = 1'b0; e.wdata = '0; e.rdata = '0;
    return e;
  endfunction

  task automatic push_fetch(input logic [24:0] a);
    ev_t e;
    exp_q.push_back(mk(EV_IACK));
    e = mk(EV_CMD); e.sel = m_sel(a); e.addr = m_loc(a);
    exp_q.push_back(e);
    e = mk(EV_IRESP); e.rdata = m_read({m_sel(a), m_loc(a)});
    last_rd = e.rdata;
    exp_q.push_back(e);
  endtask

  task automatic push_data(input int k);
    ev_t         e;
    logic [25:0] key;
    key = {m_sel(dl_addr[k]), m_loc(dl_addr[k])};
    exp_q.push_back(mk(EV_DACK));
    if (dl_we[k] && m_sel(dl_addr[k]) == 2'd0) begin
      exp_q.push_back(mk(EV_DERR));
    end else begin
      e = mk(EV_CMD); e.sel = key[25:24]; e.addr = key[23:0];
      e.we = dl_we[k]; e.wdata = dl_wd[k];
      exp_q.push_back(e);
      e = mk(EV_DRESP);
      if (dl_we[k]) begin
        m_mem[key] = dl_wd[k];
        e.rdata = '0;
      end else begin
        e.rdata = m_read(key);
      end
      last_rd = e.rdata;
      exp_q.push_back(e);
    end
  endtask

  // Grant order: data first, unless the guard has seen LIMIT overtakes of a waiting fetch.
  task automatic predict(input bit fetch, input logic [24:0] ia, input int nd);
    bit f = fetch;
    int k = 0;
    while (f || k < nd) begin
      if (f && (k == nd || (GUARD && m_cnt >= LIMIT))) begin
        push_fetch(ia); f = 1'b0; m_cnt = 0;
      end else begin
        push_data(k); m_cnt = f ? m_cnt + 1 : 0; k++;
      end
    end
  endtask

  task automatic load_data(input int k);
    d_we = dl_we[k]; d_addr = dl_addr[k]; d_wdata = dl_wd[k]; d_req = 1'b1;
  endtask

  task automatic drain();
    for (int c = 0; c < 500 && exp_q.size() != 0; c++) @(posedge clk);
    check("drain_all_events", 64'(exp_q.size()), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic run(input bit fetch, input logic [24:0] ia, input int nd);
    int k = 0;
    predict(fetch, ia, nd);
    @(negedge clk);
    i_addr = ia; i_req = fetch;
    if (nd > 0) load_data(0);
    for (int c = 0; c < 2000 && (i_req || d_req); c++) begin
      @(posedge clk); #1;
      if (i_ack) i_req = 1'b0;
      if (d_ack) begin
        k++;
        if (k < nd) load_data(k);
        else d_req = 1'b0;
      end
    end
    check("all_requests_granted", {62'b0, i_req, d_req}, 0);
    i_req = 1'b0; d_req = 1'b0;
    drain();
  endtask

  function automatic logic [24:0] rand_addr();
    logic [24:0] base;
    case ($urandom_range(0, 2))
      0: base = 25'h000_0000;
      1: base = 25'h100_0000;
      default: base = 25'h180_0000;
    endcase
    if ($urandom_range(0, 3) == 0) return base | 25'($urandom_range(0, 32'h7F_FFFF));
    return base | 25'($urandom_range(0, 31));
  endfunction

  // Engine: memory-backed model of the QSPI transfer engine.
  initial begin : engine
    logic [25:0] key;
    logic        we;
    logic [31:0] wd;
    int          dly;
    bit          aborted;
    ctrl_done = 1'b0; ctrl_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (spur_pulse) begin
        ctrl_done = 1'b1; ctrl_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        ctrl_done = 1'b0; spur_pulse = 1'b0;
      end else if (rst_n && ctrl_start) begin
        key = {ctrl_sel, ctrl_addr}; we = ctrl_we; wd = ctrl_wdata;
        dly = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 8));
        aborted = 1'b0;
        for (int c = 0; c < dly; c++) begin
          @(posedge clk); #1;
          if (!rst_n) aborted = 1'b1;
        end
        if (!aborted) begin
          ctrl_done  = 1'b1;
          ctrl_rdata = we ? 32'h0 : (e_mem.exists(key) ? e_mem[key] : init_word(key));
          if (we) e_mem[key] = wd;
          @(posedge clk); #1;
          ctrl_done = 1'b0;
        end
      end
    end
  end

  // Monitor: pops one expected event per observed pulse.
  initial begin : monitor
    bit       prev_ack, prev_dack, prev_done;
    int       npulse;
    ev_kind_e got;
    ev_t      e;
    prev_ack = 0; prev_dack = 0; prev_done = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ack = 0; prev_dack = 0; prev_done = 0;
      end else begin
        npulse = int'(i_ack) + int'(d_ack) + int'(ctrl_start) + int'(i_rvalid)
               + int'(d_rvalid) + int'(d_err);
        if (npulse > 1) check("single_pulse_per_cycle", 64'(npulse), 1);
        if (npulse > 0) begin
          got = i_ack ? EV_IACK : d_ack ? EV_DACK : ctrl_start ? EV_CMD :
                i_rvalid ? EV_IRESP : d_rvalid ? EV_DRESP : EV_DERR;
          if (exp_q.size() == 0) begin
            check("unexpected_event", 64'(got), 64'hFF);
          end else begin
            e = exp_q.pop_front();
            check("event_kind", 64'(got), 64'(e.kind));
            if (got == e.kind) begin
              case (got)
                EV_CMD: begin
                  check("ctrl_cmd", {5'b0, ctrl_sel, ctrl_addr, ctrl_we, ctrl_we ? ctrl_wdata : 32'h0},
                        {5'b0, e.sel, e.addr, e.we, e.we ? e.wdata : 32'h0});
                  check("start_one_cycle_after_ack", 64'(prev_ack), 1);
                end
                EV_IRESP, EV_DRESP: begin
                  check("rdata", 64'(rdata), 64'(e.rdata));
                  check("rvalid_one_cycle_after_done", 64'(prev_done), 1);
                end
                EV_DERR: check("err_one_cycle_after_ack", 64'(prev_dack), 1);
                default: ;
              endcase
            end
          end
        end
        prev_ack = i_ack | d_ack; prev_dack = d_ack; prev_done = ctrl_done;
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0; i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl_outputs", {31'b0, i_ack, i_rvalid, d_ack, d_rvalid, d_err, ctrl_start,
          ctrl_we, ctrl_sel, ctrl_addr}, 0);
    check("reset_data_outputs", {rdata, ctrl_wdata}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Fetch from flash, engine finishes after 10 cycles.
    m_mem[{2'd0, 24'h000100}] = 32'hDEAD_BEEF;
    e_mem[{2'd0, 24'h000100}] = 32'hDEAD_BEEF;
    fixed_dly = 10;
    run(1'b1, 25'h000_0100, 0);
    fixed_dly = 0;

    // Write to RAM B, then read it back.
    dl_we[0] = 1'b1; dl_addr[0] = 25'h180_0010; dl_wd[0] = 32'h1234_5678;
    dl_we[1] = 1'b0; dl_addr[1] = 25'h180_0010; dl_wd[1] = '0;
    run(1'b0, '0, 2);

    // Flash write errors out; the concurrent fetch is served afterwards.
    dl_we[0] = 1'b1; dl_addr[0] = 25'h000_0040; dl_wd[0] = 32'hCAFE_F00D;
    run(1'b1, 25'h000_0040, 1);

    // Data held busy back-to-back while a fetch waits.
    for (int k = 0; k < 6; k++) begin
      dl_we[k] = 1'b0; dl_addr[k] = 25'h100_0000 + 25'(k * 4); dl_wd[k] = '0;
    end
    run(1'b1, 25'h100_0200, 6);

    // Reset while the engine is busy abandons the transaction silently.
    fixed_dly = 20;
    predict(1'b1, 25'h100_0300, 0);
    @(negedge clk); i_addr = 25'h100_0300; i_req = 1'b1;
    for (int c = 0; c < 50 && i_req; c++) begin
      @(posedge clk); #1;
      if (i_ack) i_req = 1'b0;
    end
    for (int c = 0; c < 50 && exp_q.size() > 1; c++) @(posedge clk);
    check("cmd_issued_before_reset", 64'(exp_q.size()), 1);
    i_req = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    exp_q.delete(); m_cnt = 0; last_rd = '0;
    @(negedge clk);
    check("midreset_ctrl_outputs", {31'b0, i_ack, i_rvalid, d_ack, d_rvalid, d_err, ctrl_start,
          ctrl_we, ctrl_sel, ctrl_addr}, 0);
    check("midreset_data_outputs", {rdata, ctrl_wdata}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fixed_dly = 0;
    repeat (25) @(posedge clk);
    run(1'b1, 25'h100_0300, 0);

    // Spurious engine completion while idle must be ignored.
    spur_pulse = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rdata_held_after_spurious_done", 64'(rdata), 64'(last_rd));
    run(1'b1, 25'h000_0100, 0);

    // Randomized mixes of fetch and data traffic.
    for (int it = 0; it < 40; it++) begin
      int nd;
      bit f;
      nd = int'($urandom_range(0, 3));
      f  = bit'($urandom_range(0, 1));
      if (nd == 0) f = 1'b1;
      for (int k = 0; k < nd; k++) begin
        dl_we[k] = bit'($urandom_range(0, 1));
        dl_addr[k] = rand_addr();
        dl_wd[k] = $urandom;
      end
      run(f, rand_addr(), nd);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/qspi_bus_arbiter.md
Name: qspi_bus_arbiter

Overview:
- Shares the single QSPI port (flash CS, RAM A CS, RAM B CS) between the CPU instruction-fetch and data-access requesters.
- Decodes the target device from a 25-bit address and arbitrates, data side first.
- Sequences one transaction at a time through the existing QSPI transfer engine using a start/done handshake.
- Returns read data or an error pulse to the winning requester.

Parameters:
- ADDR_W, 25, requester address width; bit 24 selects flash (0) or RAM (1), bit 23 selects RAM A (0) or RAM B (1).
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch is pending (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  instruction fetch request; held high until i_ack
- i_addr  in  25  fetch address
- i_ack  out  1  one-cycle grant pulse to fetcher
- i_rvalid  out  1  one-cycle fetch data valid
- d_req  in  1  data request; held high until d_ack
- d_we  in  1  data write enable
- d_addr  in  25  data address
- d_wdata  in  32  write data
- d_ack  out  1  one-cycle grant pulse to data side
- d_rvalid  out  1  one-cycle completion pulse (read data valid, or write done)
- d_err  out  1  one-cycle error pulse: write to flash
- rdata  out  32  read data, valid with i_rvalid/d_rvalid
- ctrl_start  out  1  one-cycle transaction start to QSPI engine
- ctrl_sel  out  2  0 flash, 1 RAM A, 2 RAM B; 3 never driven
- ctrl_addr  out  24  device-local address (addr[23:0] for flash, addr[22:0] zero-extended for RAM)
- ctrl_we  out  1  write transaction
- ctrl_wdata  out  32  write data to engine
- ctrl_done  in  1  one-cycle engine completion
- ctrl_rdata  in  32  engine read data, valid with ctrl_done

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; grant owner cleared; starve counter 0. Reset mid-transaction abandons it with no response pulse. Requesters re-issue after reset.
- States: IDLE, ISSUE, WAIT, RESP, ERR.
- IDLE: on any req, pick a winner, pulse the matching *_ack, and latch sel/addr/we/wdata.
  - Data write to flash (d_addr[24]=0, d_we=1): go to ERR.
  - Otherwise go to ISSUE.
- ISSUE: ctrl_start=1 for exactly one cycle with the latched ctrl_* values, then WAIT.
- WAIT: ctrl_* held stable. On ctrl_done, latch ctrl_rdata into rdata and go to RESP.
- RESP: pulse i_rvalid or d_rvalid (one cycle); rdata held until the next RESP. Return to IDLE.
- ERR: pulse d_err for one cycle; ctrl_start is never asserted. Return to IDLE.
- Latency: request to ctrl_start = 2 cycles (IDLE ack, ISSUE). ctrl_done to rvalid = 1 cycle. Minimum gap between back-to-back grants = 1 IDLE cycle.
- Arbitration: with both requests high in IDLE, data wins. A request arriving during ISSUE/WAIT/RESP waits for IDLE.
- Instruction fetch may target any device; fetch writes do not exist.
- ctrl_done outside WAIT is ignored.
- A req dropped before ack is legal and is simply not granted.

Optional Feature:
- Macro: QSPI_ARB_STARVE_GUARD_EN.
- Defined:
  - 3-bit counter increments on each data grant made while i_req is high.
  - At STARVE_LIMIT, the next IDLE with i_req high grants fetch regardless of d_req.
  - Counter clears on any fetch grant, or on a data grant while i_req is low.
- Undefined: strict data priority; no counter flops.

Decomposition:
- Package qspi_arb_pkg holds:
  - state enum
  - device select constants SEL_FLASH=0, SEL_RAM_A=1, SEL_RAM_B=2
  - address bit positions 24/23
  - a decode function returning sel and local address
- No sub-module; single FSM plus latches, about 200 lines.

Test Plan:
- Fetch i_addr=0x000100, engine done after 10 cycles with 0xDEADBEEF -> i_ack at T0, ctrl_start at T1 with sel=0 addr=0x000100, i_rvalid and rdata=0xDEADBEEF exactly one cycle after ctrl_done.
- Data write d_addr=0x1800010 wdata=0x12345678 -> ctrl_sel=2, ctrl_addr=0x000010, ctrl_we=1, d_rvalid after done.
- Data write d_addr=0x0000040 -> d_err one cycle after d_ack, ctrl_start never asserted, fetch then serviced normally.
- i_req and d_req high together every cycle, no guard -> data granted every time, i_ack never pulses. With QSPI_ARB_STARVE_GUARD_EN and STARVE_LIMIT=4 -> pattern of 4 data grants then 1 fetch grant.
- rst_n low during WAIT, then released -> no rvalid/err pulse, all outputs 0, new fetch completes normally.
- Spurious ctrl_done in IDLE -> no rvalid and no state change.
